// File: rtl/csa_seq_adder_pkg.sv
// Shared types and constants for the sequential carry-select adder.
// State encodings are plain constants so legacy code can compare them numerically.
package csa_seq_adder_pkg;

  localparam int SLICE_W = 4;

  typedef logic [1:0] state_t;

  localparam state_t IDLE = 2'd0;
  localparam state_t RUN  = 2'd1;
  localparam state_t DONE = 2'd2;

endpackage

// File: rtl/csa_nibble.sv
// 4-bit carry-select adder: both carry-in cases are rippled up front, then cin picks one.
// Purely combinational, no handshake.
module csa_nibble
  import csa_seq_adder_pkg::*;
(
  input  logic [SLICE_W-1:0] a,
  input  logic [SLICE_W-1:0] b,
  input  logic               cin,
  output logic [SLICE_W-1:0] sum,
  output logic               cout
);

  logic [SLICE_W:0] sum_c0;
  logic [SLICE_W:0] sum_c1;

  assign sum_c0 = {1'b0, a} + {1'b0, b};
  assign sum_c1 = {1'b0, a} + {1'b0, b} + (SLICE_W+1)'(1);

  assign {cout, sum} = cin ? sum_c1 : sum_c0;

endmodule

// File: rtl/csa_seq_adder.sv
// Wide add/sub through one shared nibble slice, LSB nibble first; result after WIDTH/4 cycles.
// Takes operands only in IDLE; holds sum/cout in DONE until out_ready.
module csa_seq_adder
  import csa_seq_adder_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int NIB = WIDTH / SLICE_W;
  localparam int IW  = (NIB > 1) ? $clog2(NIB) : 1;
  localparam logic [IW-1:0] LAST = IW'(NIB - 1);

  state_t             state;
  logic [IW-1:0]      idx;
  logic [WIDTH-1:0]   op_a;
  logic [WIDTH-1:0]   op_b;
  logic               carry;
  logic [SLICE_W-1:0] nib_a;
  logic [SLICE_W-1:0] nib_b;
  logic [SLICE_W-1:0] nib_s;
  logic               nib_c;
  logic               accept;

  // Handshake outputs come straight from state, never from the inputs.
  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign accept    = in_valid & in_ready;

  assign nib_a = op_a[SLICE_W*idx +: SLICE_W];
  assign nib_b = op_b[SLICE_W*idx +: SLICE_W];

  csa_nibble u_nibble (
    .a    (nib_a),
    .b    (nib_b),
    .cin  (carry),
    .sum  (nib_s),
    .cout (nib_c)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      idx   <= '0;
      op_a  <= '0;
      op_b  <= '0;
      carry <= 1'b0;
      sum   <= '0;
      cout  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            // Subtraction is a + ~b + 1, so sub forces the initial carry.
            op_a  <= a;
            op_b  <= sub ? ~b : b;
            carry <= sub | cin;
            idx   <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          sum[SLICE_W*idx +: SLICE_W] <= nib_s;
          carry <= nib_c;
          if (idx == LAST) begin
            cout  <= nib_c;
            state <= DONE;
          end else begin
            idx <= idx + IW'(1);
          end
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/csa_seq_adder.md
# csa_seq_adder

Multi-cycle wide adder/subtractor that sequences one shared 4-bit carry-select nibble adder across WIDTH/4 cycles, least-significant nibble first, with the carry registered between nibbles. Sits between an operand producer and a result consumer, each with a valid/ready handshake. It trades latency for area: one nibble slice serves any operand width.

## Interface
- WIDTH, 16, operand/result width; must be a multiple of 4, minimum 4.
- clk  in  1  rising-edge clock.
- rst  in  1  reset, asynchronous, active-high.
- in_valid  in  1  operand request.
- in_ready  out  1  block can accept; high only in IDLE.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- cin  in  1  carry-in for add; ignored when sub=1.
- sub  in  1  1 = compute a - b (two's complement).
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts result.
- sum  out  WIDTH  result.
- cout  out  1  carry-out; for sub, 1 = no borrow (a >= b unsigned).

## Operation
- NIB = WIDTH/4.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready: latch A=a, B = sub ? ~b : b, carry = sub ? 1 : cin.
  - Clear idx; go to RUN.
- RUN, each cycle:
  - The slice adds A[4*idx+:4] + B[4*idx+:4] + carry.
  - Slice sum goes to sum register nibble idx; carry <= slice cout; idx++.
  - After nibble NIB-1: cout <= slice cout; go to DONE.
- DONE:
  - out_valid=1; sum and cout held stable.
  - On out_ready: go to IDLE.
  - No new operand is accepted in the same cycle.
- Inputs a, b, cin and sub are sampled only at acceptance. Changes during RUN/DONE have no effect.
- in_valid is ignored outside IDLE.
- idx width is clog2(NIB), minimum 1 bit. idx never wraps within one operation.
- Arithmetic is modulo 2^WIDTH; cout is bit WIDTH of the full sum.
- Reset (any state, including mid-RUN):
  - state=IDLE, idx=0, carry=0, sum=0, cout=0.
  - The operation in flight is discarded; no out_valid pulse.
- Reset values of outputs: in_ready=1, out_valid=0, sum=0, cout=0.

## Timing
- Acceptance edge = T.
- RUN occupies edges T+1 … T+NIB.
- out_valid rises after edge T+NIB, so latency is NIB cycles (4 for WIDTH=16).
- Result handshake at edge D → in_ready is high from D+1.
- Minimum period per operation is NIB+2 cycles with out_ready tied high.
- in_ready and out_valid are decoded from registered state only; there is no combinational path from in_valid or out_ready.
- The slice path is combinational within one cycle: nibble mux from idx, then the carry-select adder, then the sum/carry registers.

## Structure
- Shared package holds:
  - state typedef (IDLE/RUN/DONE);
  - localparam SLICE_W=4.
- Sub-module csa_nibble: 4-bit carry-select adder.
  - Two precomputed rippled sums (carry-in 0 and 1), selected by carry-in.
  - Ports a[3:0], b[3:0], cin, sum[3:0], cout.
  - Instantiated once.
- Top module contains the FSM, idx counter, operand registers, carry register and sum register.

## Test plan
All cases use WIDTH=16 unless noted.
- a=0x1234, b=0x1111, cin=0, sub=0 → sum=0x2345, cout=0. out_valid exactly 4 cycles after acceptance.
- a=0xFFFF, b=0x0001, cin=0 → sum=0x0000, cout=1 (carry crosses every nibble). Also a=0x0FFF, b=0, cin=1 → sum=0x1000, cout=0.
- Subtract: sub=1, a=0x0007, b=0x0005 → sum=0x0002, cout=1. Then a=0x0005, b=0x0007 → sum=0xFFFE, cout=0.
- Backpressure: out_ready low for 10 cycles in DONE → sum and cout stable, in_ready=0. Toggling in_valid/a/b meanwhile has no effect. out_ready high → IDLE next cycle.
- Reset pulse during RUN at idx=2 → out_valid=0, sum=0, cout=0, in_ready=1 immediately. A following op a=0x00FF, b=0x0001 → sum=0x0100.
- WIDTH=4 build: a=0x9, b=0x8, cin=1 → sum=0x2, cout=1, latency 1 cycle.
